// File: rtl/ifetch_if.sv
// Fetch-stage bundle: ROM address/data, redirect from execute, and the
// decode-facing response channel.
//
// Handshake: out_valid qualifies out_pc/out_instr/out_fault; a word is
// transferred on a rising edge where out_valid && out_ready. While
// out_valid is high and out_ready is low, the presented word is held stable.
interface ifetch_if #(
  parameter int ROM_SIZE = 8192
);
  localparam int RomWidth = $clog2(ROM_SIZE / 4);

  logic [RomWidth-1:0] rom_adr;
  logic [31:0]         rom_dat;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_pc;
  logic [31:0]         out_instr;
  logic                out_fault;

  // Fetch stage side.
  modport master (
    output rom_adr,
    input  rom_dat,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_fault
  );

  // ROM / execute / decode side.
  modport slave (
    input  rom_adr,
    output rom_dat,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_fault
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage in front of a registered boot ROM. The ROM reads
// every cycle, so a stall re-presents the address of the held word instead
// of buffering it. Faulting PCs (misaligned or past the ROM) produce one
// flagged word and then halt fetch until a redirect.
module ifetch #(
  parameter int          ROM_SIZE = 8192,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus,
  output logic     dbg_halt_o
);
  localparam int          RomWidth  = $clog2(ROM_SIZE / 4);
  localparam logic [31:0] RomLimit  = 32'(ROM_SIZE);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} mode_e;

  mode_e       mode_q;
  logic [31:0] pc_q;
  logic [31:0] rsp_pc_q;
  logic        rsp_valid_q;

  logic stall;
  logic fault;
  logic xfer;

  // Response channel: a redirect squashes the presented word this cycle.
  always_comb begin
    bus.out_valid = rsp_valid_q && !bus.redirect_valid;
    bus.out_pc    = rsp_pc_q;
    bus.out_fault = fault;
    bus.out_instr = fault ? 32'h0 : bus.rom_dat;
  end

  assign fault      = rsp_valid_q && ((rsp_pc_q[1:0] != 2'b00) || (rsp_pc_q >= RomLimit));
  assign stall      = bus.out_valid && !bus.out_ready;
  assign xfer       = bus.out_valid && bus.out_ready;
  assign dbg_halt_o = (mode_q == HALT);

  // ROM address: redirect target, else re-read the held word, else next PC.
  always_comb begin
    bus.rom_adr = pc_q[RomWidth+1:2];
    if (bus.redirect_valid) begin
      bus.rom_adr = bus.redirect_pc[RomWidth+1:2];
    end else if (stall) begin
      bus.rom_adr = rsp_pc_q[RomWidth+1:2];
    end
  end

  // Fetch FSM: redirect > stall > halt > fault retirement > sequential fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= 32'h0;
      mode_q      <= RUN;
    end else if (bus.redirect_valid) begin
      rsp_valid_q <= 1'b1;
      rsp_pc_q    <= bus.redirect_pc;
      pc_q        <= bus.redirect_pc + 32'd4;
      mode_q      <= RUN;
    end else if (stall) begin
      // Hold everything; the ROM re-reads rsp_pc_q.
    end else if (mode_q == HALT) begin
      // No fetch until a redirect.
    end else if (xfer && fault) begin
      rsp_valid_q <= 1'b0;
      mode_q      <= HALT;
    end else begin
      rsp_valid_q <= 1'b1;
      rsp_pc_q    <= pc_q;
      pc_q        <= pc_q + 32'd4;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a registered ROM model, directed scenario tasks and a
// transfer scoreboard fed with expected {fault, pc, instr} entries.
module tb_ifetch;
  localparam int ROM_SIZE = 8192;

  logic clk;
  logic rst;
  logic dbg_halt;

  int tests_run;
  int fails;

  logic [64:0] exp_q[$];

  ifetch_if #(.ROM_SIZE(ROM_SIZE)) bus ();

  ifetch #(.ROM_SIZE(ROM_SIZE), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_halt_o (dbg_halt)
  );

  // Clock: period 20, posedge at 10, 30, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] rom_fn(input logic [10:0] a);
    return {5'h15, a, 5'h0A, a} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [64:0] exp_word(input logic [31:0] pc);
    logic f;
    f = (pc[1:0] != 2'b00) || (pc >= 32'd8192);
    return {f, pc, (f ? 32'h0 : rom_fn(pc[12:2]))};
  endfunction

  // Registered boot ROM model.
  always @(posedge clk) bus.rom_dat <= rom_fn(bus.rom_adr);

  // Scoreboard: every transfer pops and compares one expected word.
  always begin
    @(negedge clk);
    #8;
    if (bus.out_valid && bus.out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL xfer_unexpected: got pc=%h instr=%h fault=%0d, required no transfer",
                 bus.out_pc, bus.out_instr, bus.out_fault);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({bus.out_fault, bus.out_pc, bus.out_instr} !== e) begin
          fails++;
          $display("FAIL xfer: got fault=%0d pc=%h instr=%h, required fault=%0d pc=%h instr=%h",
                   bus.out_fault, bus.out_pc, bus.out_instr, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // Inputs change 2 time units after the falling edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    #1;
    tests_run++;
    if ({bus.out_valid, bus.out_pc, bus.out_fault, dbg_halt} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got valid=%0d pc=%h fault=%0d halt=%0d, required 0/0/0/0",
               bus.out_valid, bus.out_pc, bus.out_fault, dbg_halt);
    end
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(32'(4 * i)));
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      tests_run++;
      if (!bus.out_valid || bus.out_pc !== 32'(4 * i) || bus.out_fault !== 1'b0) begin
        fails++;
        $display("FAIL reset_seq[%0d]: got valid=%0d pc=%h fault=%0d, required 1/%h/0",
                 i, bus.out_valid, bus.out_pc, bus.out_fault, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.rom_adr !== 11'd2) begin
      fails++;
      $display("FAIL stall_redirect: got valid=%0d adr=%0d, required 0/2", bus.out_valid, bus.rom_adr);
    end
    held = rom_fn(11'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.redirect_valid = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      tests_run++;
      if (!bus.out_valid || bus.out_pc !== 32'h8 || bus.rom_adr !== 11'd2 || bus.out_instr !== held) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got valid=%0d pc=%h adr=%0d instr=%h, required 1/8/2/%h",
                 i, bus.out_valid, bus.out_pc, bus.rom_adr, bus.out_instr, held);
      end
    end
    tick();
    bus.out_ready = 1'b1;
    exp_q.push_back(exp_word(32'h8));
    exp_q.push_back(exp_word(32'hC));
    tick();
    #1;
    tests_run++;
    if (!bus.out_valid || bus.out_pc !== 32'hC) begin
      fails++;
      $display("FAIL stall_release: got valid=%0d pc=%h, required 1/0000000c", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_redirect();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL redirect_squash: got valid=%0d, required 0", bus.out_valid);
    end
    exp_q.push_back(exp_word(32'h100));
    exp_q.push_back(exp_word(32'h104));
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      tests_run++;
      if (!bus.out_valid || bus.out_pc !== 32'(32'h100 + 4 * i)) begin
        fails++;
        $display("FAIL redirect_seq[%0d]: got valid=%0d pc=%h, required 1/%h",
                 i, bus.out_valid, bus.out_pc, 32'(32'h100 + 4 * i));
      end
    end
  endtask

  task automatic test_fault();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    exp_q.push_back(exp_word(32'h102));
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (!bus.out_valid || bus.out_fault !== 1'b1 || bus.out_instr !== 32'h0 || bus.out_pc !== 32'h102) begin
      fails++;
      $display("FAIL fault_word: got valid=%0d fault=%0d instr=%h pc=%h, required 1/1/0/102",
               bus.out_valid, bus.out_fault, bus.out_instr, bus.out_pc);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || dbg_halt !== 1'b1) begin
        fails++;
        $display("FAIL fault_halt[%0d]: got valid=%0d halt=%0d, required 0/1", i, bus.out_valid, dbg_halt);
      end
    end
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    exp_q.push_back(exp_word(32'h200));
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (!bus.out_valid || bus.out_pc !== 32'h200 || bus.out_fault !== 1'b0 || dbg_halt !== 1'b0) begin
      fails++;
      $display("FAIL fault_resume: got valid=%0d pc=%h fault=%0d halt=%0d, required 1/200/0/0",
               bus.out_valid, bus.out_pc, bus.out_fault, dbg_halt);
    end
  endtask

  task automatic test_rom_end();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'(ROM_SIZE - 8);
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_word(32'(ROM_SIZE - 8 + 4 * i)));
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      tests_run++;
      if (!bus.out_valid || bus.out_pc !== 32'(ROM_SIZE - 8 + 4 * i) || bus.out_fault !== (i == 2)) begin
        fails++;
        $display("FAIL rom_end[%0d]: got valid=%0d pc=%h fault=%0d, required 1/%h/%0d",
                 i, bus.out_valid, bus.out_pc, bus.out_fault, 32'(ROM_SIZE - 8 + 4 * i), (i == 2));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || dbg_halt !== 1'b1) begin
        fails++;
        $display("FAIL rom_end_halt[%0d]: got valid=%0d halt=%0d, required 0/1", i, bus.out_valid, dbg_halt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    logic        was_stall;
    logic        done;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    base = 32'($urandom_range(0, 1999) * 4);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = base;
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_word(base + 32'(4 * i)));
    was_stall = 1'b0;
    done = 1'b0;
    held_pc = 32'h0;
    held_instr = 32'h0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      bus.redirect_valid = 1'b0;
      if (exp_q.size() == 0) begin
        bus.out_ready = 1'b0;
        done = 1'b1;
        break;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (was_stall) begin
        tests_run++;
        if (bus.out_pc !== held_pc || bus.out_instr !== held_instr) begin
          fails++;
          $display("FAIL b2b_stable: got pc=%h instr=%h, required %h/%h",
                   bus.out_pc, bus.out_instr, held_pc, held_instr);
        end
      end
      was_stall = bus.out_valid && !bus.out_ready;
      held_pc = bus.out_pc;
      held_instr = bus.out_instr;
    end
    tests_run++;
    if (!done) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_async_reset();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40) begin
      fails++;
      $display("FAIL arst_pre: got valid=%0d pc=%h, required 1/40", bus.out_valid, bus.out_pc);
    end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_fault !== 1'b0) begin
      fails++;
      $display("FAIL arst_drop: got valid=%0d pc=%h fault=%0d, required 0/0/0",
               bus.out_valid, bus.out_pc, bus.out_fault);
    end
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.push_back(exp_word(32'h0));
    exp_q.push_back(exp_word(32'h4));
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      tests_run++;
      if (!bus.out_valid || bus.out_pc !== 32'(4 * i)) begin
        fails++;
        $display("FAIL arst_restart[%0d]: got valid=%0d pc=%h, required 1/%h",
                 i, bus.out_valid, bus.out_pc, 32'(4 * i));
      end
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    test_reset();
    test_stall();
    test_redirect();
    test_fault();
    test_rom_end();
    test_back_to_back();
    test_async_reset();
    tick();
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d words pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage sitting directly upstream of the boot ROM: it generates the ROM word address and consumes the registered 32-bit ROM data one cycle later. It presents fetched instructions to decode with a valid/ready handshake, and accepts PC redirects from execute. Faults are flagged for out-of-range and misaligned PCs. Because the ROM reads every cycle with no enable, stalls are absorbed by re-presenting the same address rather than by buffering.

## Interface
- ROM_SIZE, 8192: ROM size in bytes; must match the ROM instance. Derived RomWidth = $clog2(ROM_SIZE/4).
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rom_adr  out  RomWidth  word address to ROM; combinational.
- rom_dat  in  32  ROM data for the address presented on the previous edge.
- redirect_valid  in  1  take new PC this cycle.
- redirect_pc  in  32  new byte PC.
- out_valid  out  1  fetched word available.
- out_ready  in  1  decode accepts; a transfer occurs when out_valid && out_ready.
- out_pc  out  32  byte PC of the presented word.
- out_instr  out  32  instruction word; equals rom_dat, or 0 when out_fault.
- out_fault  out  1  presented PC is misaligned (pc[1:0]!=0) or out of range (pc >= ROM_SIZE).

## Operation
- State: pc_q (next sequential PC), rsp_valid_q, rsp_pc_q (PC whose data is on rom_dat), mode_q ∈ {RUN, HALT}.
- Reset values: pc_q=RESET_PC, rsp_valid_q=0, rsp_pc_q=0, mode_q=RUN. Outputs during reset: out_valid=0, out_pc=0, out_fault=0.
- stall = out_valid && !out_ready.
- rom_adr selection, in priority order:
  - redirect_valid: redirect_pc[RomWidth+1:2].
  - stall: rsp_pc_q[RomWidth+1:2].
  - otherwise: pc_q[RomWidth+1:2].
- Out-of-range or misaligned PCs still drive the truncated index; the data is ignored.
- Register update at each edge, in priority order:
  - redirect_valid: rsp_valid_q=1, rsp_pc_q=redirect_pc, pc_q=redirect_pc+4, mode_q=RUN. A redirect overrides stall and HALT.
  - stall: hold all state.
  - mode_q=HALT: hold. No fetch activity; rsp_valid_q stays 0.
  - Transfer of a faulting word: rsp_valid_q=0, mode_q=HALT.
  - Otherwise (RUN, no stall): rsp_valid_q=1, rsp_pc_q=pc_q, pc_q=pc_q+4. The sum is a 32-bit add that wraps modulo 2^32.
- Output mapping:
  - out_valid = rsp_valid_q && !redirect_valid. A redirect squashes the word in the same cycle; no transfer can occur.
  - out_pc = rsp_pc_q.
  - out_fault = rsp_valid_q && (rsp_pc_q[1:0]!=0 || rsp_pc_q >= ROM_SIZE).
- Sequential fetch past the ROM end yields exactly one faulting word at PC=ROM_SIZE, then HALT. Only a redirect resumes fetch.
- Faults are not sticky across redirects.
- Asserting rst mid-operation immediately clears rsp_valid_q and discards in-flight data.

## Timing
- Fetch latency is one cycle from address to out_valid. The first out_valid occurs at the first edge after rst deasserts, with out_pc=RESET_PC.
- Redirect asserted in cycle N: out_valid=0 in cycle N; out_valid=1 in cycle N+1 with out_pc=redirect_pc.
- Throughput is one word per cycle while out_ready=1.
- During a stall, out_pc and out_instr are stable every cycle, because the ROM re-reads the same word.
- A transfer in cycle N with no redirect and no fault presents PC+4 in cycle N+1.

## Test plan
- Reset release with RESET_PC=0 and out_ready=1: cycles 1..4 show out_pc 0,4,8,12 with out_instr equal to the ROM contents; out_fault=0.
- out_ready low for 3 cycles at out_pc=8: rom_adr=2 and out_pc=8 are held all three cycles, out_instr is stable, and the next word after release is PC 12 (no skip, no duplicate).
- redirect_pc=0x100 asserted while out_valid=1 and out_ready=1: no transfer that cycle; the next cycle shows out_pc=0x100, then 0x104.
- redirect_pc=0x102: one word with out_fault=1 and out_instr=0. After it is accepted, out_valid stays 0 for 10 cycles. A redirect to 0x200 then resumes fetch.
- Sequential run from ROM_SIZE-8 (8184): PCs 8184 and 8188 are normal; PC 8192 has out_fault=1; then HALT.
- rst asserted mid-stall and asynchronously (between edges): out_valid drops immediately. After release, fetch restarts at RESET_PC.
